// File: rtl/readout_sequencer.sv
// readout_sequencer: per-fill channel readout sequencer (header word, exclusive channel grants, trailer word)
//
// Optional feature: define READOUT_TIMEOUT_EN to enable per-channel read timeouts.
// Ports:
//   clk, reset_n                     clock and synchronous active-low reset
//   fill_valid, fill_num, fill_ready fill-number handshake from the trigger-number FIFO
//   chan_en                          channel enable mask, captured when a fill is accepted
//   timeout_max                      READ cycle limit per channel, 0 = unlimited (timeout build only)
//   rd_req, rd_done                  one-hot readout grant and per-channel completion
//   hdr_valid, hdr_data, hdr_ready   header/trailer word handshake
//   readout_busy                     high outside IDLE, feeds the trigger manager's cm_busy
//   seq_done                         one-cycle pulse once a fill has been fully read out
//   timeout_flag                     sticky per-channel timeout flags, cleared only by reset
module readout_sequencer #(
   parameter int NCHAN     = 5,
   parameter int FILLNUM_W = 24,
   parameter int TIMEOUT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   fill_valid,
   input  logic [FILLNUM_W-1:0]   fill_num,
   output logic                   fill_ready,
   input  logic [NCHAN-1:0]       chan_en,
   input  logic [TIMEOUT_W-1:0]   timeout_max,
   output logic [NCHAN-1:0]       rd_req,
   input  logic [NCHAN-1:0]       rd_done,
   output logic                   hdr_valid,
   output logic [FILLNUM_W+7:0]   hdr_data,
   input  logic                   hdr_ready,
   output logic                   readout_busy,
   output logic                   seq_done,
   output logic [NCHAN-1:0]       timeout_flag
);
   typedef enum logic [2:0] {IDLE, HEADER, NEXT, READ, TRAILER, DONE} state_t;
   state_t state;
   logic [FILLNUM_W-1:0] fill;
   logic [NCHAN-1:0] mask, tmask, lowest;
   logic [4:0] tmask5;
   // two's-complement trick isolates the lowest pending channel
   assign lowest = mask & (~mask + NCHAN'(1));
   assign tmask5 = 5'(tmask);
   assign readout_busy = state != IDLE;
`ifdef READOUT_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] cnt;
   logic expired;
   // fires in the timeout_max-th READ cycle, so rd_req is high exactly timeout_max cycles
   assign expired = timeout_max != '0 && cnt == timeout_max - TIMEOUT_W'(1);
`else
   logic unused_timeout_max;
   assign unused_timeout_max = ^timeout_max;
`endif
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= IDLE;
         fill         <= '0;
         mask         <= '0;
         tmask        <= '0;
         fill_ready   <= 1'b0;
         rd_req       <= '0;
         hdr_valid    <= 1'b0;
         hdr_data     <= '0;
         seq_done     <= 1'b0;
         timeout_flag <= '0;
`ifdef READOUT_TIMEOUT_EN
         cnt          <= '0;
`endif
      end else begin
         seq_done <= 1'b0;
         case (state)
            IDLE: begin
               fill_ready <= 1'b1;
               if (fill_valid && fill_ready) begin
                  fill       <= fill_num;
                  mask       <= chan_en;
                  tmask      <= '0;
                  fill_ready <= 1'b0;
                  hdr_valid  <= 1'b1;
                  hdr_data   <= {8'hA5, fill_num};
                  state      <= HEADER;
               end
            end
            HEADER: begin
               if (hdr_ready) begin
                  hdr_valid <= 1'b0;
                  state     <= NEXT;
               end
            end
            NEXT: begin
               if (mask == '0) begin
                  hdr_valid <= 1'b1;
                  hdr_data  <= {3'b111, tmask5, fill};
                  state     <= TRAILER;
               end else begin
                  rd_req <= lowest;
                  state  <= READ;
`ifdef READOUT_TIMEOUT_EN
                  cnt    <= '0;
`endif
               end
            end
            READ: begin
               // completion wins over a timeout landing in the same cycle
               if ((rd_done & rd_req) != '0) begin
                  mask   <= mask & ~rd_req;
                  rd_req <= '0;
                  state  <= NEXT;
               end
`ifdef READOUT_TIMEOUT_EN
               else if (expired) begin
                  timeout_flag <= timeout_flag | rd_req;
                  tmask        <= tmask | rd_req;
                  mask         <= mask & ~rd_req;
                  rd_req       <= '0;
                  state        <= NEXT;
               end else begin
                  cnt <= cnt + TIMEOUT_W'(1);
               end
`endif
            end
            TRAILER: begin
               if (hdr_ready) begin
                  hdr_valid <= 1'b0;
                  seq_done  <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               fill_ready <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_readout_sequencer.sv
// tb_readout_sequencer: randomized self-checking bench for readout_sequencer against a fill-level model
module tb_readout_sequencer;
   localparam int NCHAN = 5;
   localparam int FW    = 24;
   localparam int TW    = 16;
`ifdef READOUT_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   logic clk = 1'b0;
   logic reset_n, fill_valid, fill_ready, hdr_valid, hdr_ready, readout_busy, seq_done;
   logic [FW-1:0] fill_num;
   logic [NCHAN-1:0] chan_en, rd_req, rd_done, timeout_flag;
   logic [TW-1:0] timeout_max;
   logic [FW+7:0] hdr_data;
   int checks = 0;
   int passes = 0;
   int delay [NCHAN];
   int rdy_mode = 0;
   bit noise_en = 1'b0;
   logic [FW+7:0] obs_w[$], exp_w[$];
   logic [NCHAN-1:0] obs_g[$], exp_g[$];
   int obs_l[$], exp_l[$];
   int done_cnt = 0, busy_cnt = 0, stab_err = 0, hot_err = 0;
   logic [NCHAN-1:0] exp_flag = '0;
   int hi, len;
   logic [NCHAN-1:0] cur;
   logic pv, pr, pn;
   logic [FW+7:0] pd;

   always #5 clk = ~clk;

   readout_sequencer dut (
      .clk(clk), .reset_n(reset_n), .fill_valid(fill_valid), .fill_num(fill_num),
      .fill_ready(fill_ready), .chan_en(chan_en), .timeout_max(timeout_max),
      .rd_req(rd_req), .rd_done(rd_done), .hdr_valid(hdr_valid), .hdr_data(hdr_data),
      .hdr_ready(hdr_ready), .readout_busy(readout_busy), .seq_done(seq_done),
      .timeout_flag(timeout_flag)
   );

   // channel responder: rd_done[i] in the delay[i]-th cycle of its grant (0 = never), optional noise elsewhere
   initial begin
      hi = 0;
      rd_done = '0;
      forever begin
         @(posedge clk); #1;
         rd_done = noise_en ? (NCHAN'($urandom) & ~rd_req) : '0;
         if (rd_req == '0) hi = 0;
         else begin
            hi++;
            for (int i = 0; i < NCHAN; i++)
               if (rd_req[i] && delay[i] == hi) rd_done[i] = 1'b1;
         end
      end
   end

   // downstream ready: 0 = always ready, 1 = random, 2 = held off
   initial begin
      hdr_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         hdr_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
   end

   // monitor: collects accepted words, grant runs and protocol violations
   initial begin
      cur = '0; len = 0; pv = 1'b0; pr = 1'b0; pn = 1'b0; pd = '0;
      forever begin
         @(negedge clk);
         if (hdr_valid && hdr_ready) obs_w.push_back(hdr_data);
         if (pv && !pr && pn && (!hdr_valid || hdr_data !== pd)) stab_err++;
         if ($countones(rd_req) > 1) hot_err++;
         if (rd_req != '0 && rd_req == cur) len++;
         else begin
            if (cur != '0) begin
               obs_g.push_back(cur);
               obs_l.push_back(len);
            end
            cur = rd_req;
            len = (rd_req != '0) ? 1 : 0;
         end
         if (seq_done) done_cnt++;
         if (readout_busy) busy_cnt++;
         pv = hdr_valid; pr = hdr_ready; pd = hdr_data; pn = reset_n;
      end
   end

   // expected words and grants for one fill, derived from the enable mask, channel delays and timeout
   task automatic build_model(input logic [FW-1:0] f, input logic [NCHAN-1:0] m, input int t);
      logic [NCHAN-1:0] tm;
      bit to;
      tm = '0;
      exp_w.delete(); exp_g.delete(); exp_l.delete();
      exp_w.push_back({8'hA5, f});
      for (int i = 0; i < NCHAN; i++) begin
         if (m[i]) begin
            to = TO_EN && t != 0 && (delay[i] == 0 || delay[i] > t);
            exp_g.push_back(NCHAN'(1) << i);
            exp_l.push_back(to ? t : delay[i]);
            if (to) tm[i] = 1'b1;
         end
      end
      exp_flag |= tm;
      exp_w.push_back({3'b111, tm, f});
   endtask

   task automatic start_fill(input logic [FW-1:0] f, input logic [NCHAN-1:0] m, input int t, output bit ok);
      int n;
      n = 0;
      timeout_max = TW'(t);
      build_model(f, m, t);
      obs_w.delete(); obs_g.delete(); obs_l.delete();
      done_cnt = 0; busy_cnt = 0; stab_err = 0; hot_err = 0;
      while (!fill_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      fill_num = f; chan_en = m; fill_valid = 1'b1;
      @(posedge clk); #1;
      fill_valid = 1'b0;
      chan_en = ~m;
      fill_num = FW'($urandom);
      ok = n < 100;
   endtask

   task automatic wait_done(output bit ok);
      int n;
      n = 0;
      while (done_cnt == 0 && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      repeat (2) begin
         @(posedge clk); #1;
      end
      ok = done_cnt != 0;
   endtask

   task automatic test_reset;
      reset_n = 1'b0; fill_valid = 1'b0; fill_num = '0; chan_en = '0; timeout_max = '0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      checks++; if (rd_req !== '0) $display("FAIL reset_rd_req: got %b expected 0", rd_req); else passes++;
      checks++; if (hdr_valid !== 1'b0) $display("FAIL reset_hdr_valid: got %b expected 0", hdr_valid); else passes++;
      checks++; if (fill_ready !== 1'b0) $display("FAIL reset_fill_ready: got %b expected 0", fill_ready); else passes++;
      checks++; if (readout_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", readout_busy); else passes++;
      checks++; if (seq_done !== 1'b0 || timeout_flag !== '0) $display("FAIL reset_done_flags: got %b %b expected 0 0", seq_done, timeout_flag); else passes++;
      reset_n = 1'b1;
      exp_flag = '0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      checks++; if (fill_ready !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", fill_ready); else passes++;
   endtask

   // fills 0..4 are the directed cases, the rest are randomized
   task automatic test_fills(input int n_rand);
      bit ok1, ok2;
      logic [FW-1:0] f;
      logic [NCHAN-1:0] m;
      int t;
      for (int k = 0; k < 5 + n_rand; k++) begin
         rdy_mode = 0; noise_en = 1'b0; t = 0;
         for (int i = 0; i < NCHAN; i++) delay[i] = 2;
         case (k)
            0: begin f = 24'h000123; m = 5'h1F; for (int i = 0; i < NCHAN; i++) delay[i] = 3; end
            1: begin f = 24'h00ABCD; m = 5'b10100; end
            2: begin f = 24'hFFFFFF; m = 5'b00000; end
            3: begin f = 24'h5A5A5A; m = 5'h1F; t = 8; delay[2] = TO_EN ? 0 : 20; end
            4: begin f = 24'h000777; m = 5'b01110; t = 4; delay[1] = 4; delay[2] = 3; delay[3] = 6; end
            default: begin
               f = FW'($urandom); m = NCHAN'($urandom); t = $urandom_range(0, 10);
               for (int i = 0; i < NCHAN; i++) delay[i] = $urandom_range(1, 12);
               rdy_mode = $urandom_range(0, 1); noise_en = 1'b1;
            end
         endcase
         start_fill(f, m, t, ok1);
         wait_done(ok2);
         checks++; if (!(ok1 && ok2)) $display("FAIL fill%0d_handshake: accepted=%0b done=%0b expected 1 1", k, ok1, ok2); else passes++;
         checks++; if (obs_w.size() != exp_w.size()) $display("FAIL fill%0d_word_count: got %0d expected %0d", k, obs_w.size(), exp_w.size()); else passes++;
         for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
            checks++; if (obs_w[i] !== exp_w[i]) $display("FAIL fill%0d_word%0d: got %h expected %h", k, i, obs_w[i], exp_w[i]); else passes++;
         end
         checks++; if (obs_g.size() != exp_g.size()) $display("FAIL fill%0d_grant_count: got %0d expected %0d", k, obs_g.size(), exp_g.size()); else passes++;
         for (int i = 0; i < exp_g.size() && i < obs_g.size(); i++) begin
            checks++;
            if (obs_g[i] !== exp_g[i] || obs_l[i] != exp_l[i])
               $display("FAIL fill%0d_grant%0d: got %b x%0d expected %b x%0d", k, i, obs_g[i], obs_l[i], exp_g[i], exp_l[i]);
            else passes++;
         end
         checks++; if (done_cnt != 1) $display("FAIL fill%0d_seq_done: got %0d pulses expected 1", k, done_cnt); else passes++;
         checks++; if (timeout_flag !== exp_flag) $display("FAIL fill%0d_timeout_flag: got %b expected %b", k, timeout_flag, exp_flag); else passes++;
         checks++; if (hot_err != 0 || stab_err != 0) $display("FAIL fill%0d_protocol: onehot_err=%0d stable_err=%0d expected 0 0", k, hot_err, stab_err); else passes++;
         if (k == 2) begin
            checks++; if (busy_cnt != 4) $display("FAIL empty_busy_cycles: got %0d expected 4", busy_cnt); else passes++;
         end
      end
      rdy_mode = 0; noise_en = 1'b0;
   endtask

   task automatic test_hdr_stall;
      bit ok1, ok2;
      rdy_mode = 2;
      for (int i = 0; i < NCHAN; i++) delay[i] = 2;
      start_fill(24'h00C0DE, 5'b00001, 0, ok1);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checks++;
         if (hdr_valid !== 1'b1 || hdr_data !== 32'hA500C0DE || fill_ready !== 1'b0)
            $display("FAIL stall_cycle%0d: got valid=%b data=%h ready=%b expected 1 a500c0de 0", c, hdr_valid, hdr_data, fill_ready);
         else passes++;
      end
      @(posedge clk); #1;
      rdy_mode = 0;
      wait_done(ok2);
      checks++; if (!(ok1 && ok2)) $display("FAIL stall_handshake: accepted=%0b done=%0b expected 1 1", ok1, ok2); else passes++;
      checks++;
      if (obs_w.size() != 2 || obs_w[0] !== exp_w[0] || obs_w[1] !== exp_w[1])
         $display("FAIL stall_words: got %0d words first %h expected 2 words %h %h", obs_w.size(), obs_w.size() > 0 ? obs_w[0] : '0, exp_w[0], exp_w[1]);
      else passes++;
   endtask

   task automatic test_reset_mid_read;
      bit ok1;
      int n, d0, w0;
      for (int i = 0; i < NCHAN; i++) delay[i] = 0;
      start_fill(24'h0BEEF0, 5'h1F, 0, ok1);
      n = 0;
      while (rd_req == '0 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      checks++; if (!ok1 || n >= 50) $display("FAIL midreset_reach_read: got rd_req=%b expected nonzero", rd_req); else passes++;
      reset_n = 1'b0;
      @(posedge clk); #1;
      checks++; if (rd_req !== '0 || readout_busy !== 1'b0) $display("FAIL midreset_outputs: got rd_req=%b busy=%b expected 0 0", rd_req, readout_busy); else passes++;
      checks++; if (hdr_valid !== 1'b0 || timeout_flag !== '0) $display("FAIL midreset_hdr_flags: got %b %b expected 0 0", hdr_valid, timeout_flag); else passes++;
      reset_n = 1'b1;
      exp_flag = '0;
      d0 = done_cnt; w0 = obs_w.size();
      repeat (2) begin
         @(posedge clk); #1;
      end
      checks++; if (fill_ready !== 1'b1) $display("FAIL midreset_fill_ready: got %b expected 1", fill_ready); else passes++;
      repeat (10) begin
         @(posedge clk); #1;
      end
      checks++; if (done_cnt != d0 || obs_w.size() != w0) $display("FAIL midreset_no_trailer: got done=%0d words=%0d expected %0d %0d", done_cnt, obs_w.size(), d0, w0); else passes++;
   endtask

   initial begin
      for (int i = 0; i < NCHAN; i++) delay[i] = 2;
      test_reset;
      test_fills(20);
      test_hdr_stall;
      test_reset_mid_read;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
